uart_autobaud_ctrl: RTL and testbench

//   Generates the 16x-oversample baud_tick that drives the UART receiver, and can set its divisor.

---
 rtl/uart_autobaud_ctrl_pkg.sv | 16 +
 rtl/uart_autobaud_ctrl_if.sv | 25 ++
 rtl/uart_autobaud_ctrl_baud_gen.sv | 35 +++
 rtl/uart_autobaud_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_autobaud_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared types and constants for the UART autobaud controller.
// Build option UART_AUTOBAUD_RX_SYNC_EN (used in the top) adds a 2-flop rx synchronizer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FALL,
        MEASURE,
        CALC
    } ab_state_e;

    localparam int DEFAULT_DIV = 325;
    localparam int SYNC_EDGES  = 5;
    localparam int OVS_SHIFT   = 7;

endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// Host/datapath side signals of the autobaud controller.
// master drives rx and the host controls; slave is the controller.
interface uart_autobaud_ctrl_if #(
    parameter int DIV_W = 16
);
    logic             rx;
    logic             autobaud_start;
    logic             manual_div_we;
    logic [DIV_W-1:0] manual_div;
    logic             baud_tick;
    logic [DIV_W-1:0] div_out;
    logic             locked;
    logic             busy;
    logic             ab_error;

    modport master (
        output rx, autobaud_start, manual_div_we, manual_div,
        input  baud_tick, div_out, locked, busy, ab_error
    );

    modport slave (
        input  rx, autobaud_start, manual_div_we, manual_div,
        output baud_tick, div_out, locked, busy, ab_error
    );
endinterface

// File: rtl/uart_autobaud_ctrl_baud_gen.sv
// Divisor register and free-running counter producing the 16x baud_tick.
// Loading a divisor restarts the count so the first new tick lands div cycles later.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    output logic             baud_tick,
    output logic [DIV_W-1:0] div_out
);
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= DIV_W'(DEFAULT_DIV);
            cnt_reg <= '0;
        end else if (div_load) begin
            div_reg <= div;
            cnt_reg <= '0;
        end else if (baud_tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

    assign baud_tick = (cnt_reg == div_reg - DIV_W'(1));
    assign div_out   = div_reg;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Baud tick owner for the RX path: divisor comes from a host write or from timing a 0x55 sync char.
// Define UART_AUTOBAUD_RX_SYNC_EN when rx is asynchronous to clk.
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int MEAS_W = DIV_W + 7
) (
    input logic                 clk,
    input logic                 rst,
    uart_autobaud_ctrl_if.slave bus
);
    localparam int Q_W = MEAS_W + 1 - OVS_SHIFT;

    ab_state_e         state_reg, state_next;
    logic [MEAS_W-1:0] meas_reg, meas_next;
    logic [2:0]        edge_reg, edge_next;
    logic [MEAS_W-1:0] n_reg, n_next;
    logic              locked_reg, locked_next;
    logic              err_reg, err_next;
    logic              rx_q_reg;
    logic              rxs;
    logic              fall;
    logic              div_load;
    logic [DIV_W-1:0]  div_load_val;

`ifdef UART_AUTOBAUD_RX_SYNC_EN
    logic [1:0] sync_reg;
    always_ff @(posedge clk) begin
        if (rst) sync_reg <= 2'b11;
        else     sync_reg <= {sync_reg[0], bus.rx};
    end
    assign rxs = sync_reg[1];
`else
    assign rxs = bus.rx;
`endif

    always_ff @(posedge clk) begin
        if (rst) rx_q_reg <= 1'b1;
        else     rx_q_reg <= rxs;
    end
    assign fall = rx_q_reg & ~rxs;

    // N spans 8 bit times = 128 oversample ticks, so divide by 128 with round-to-nearest.
    logic [MEAS_W:0]  rounded;
    logic [Q_W-1:0]   quot;
    logic [63:0]      quot_wide;
    logic             quot_ok;
    assign rounded   = {1'b0, n_reg} + (MEAS_W+1)'(1 << (OVS_SHIFT - 1));
    assign quot      = rounded[MEAS_W:OVS_SHIFT];
    assign quot_wide = 64'(quot);
    assign quot_ok   = (quot_wide >= 64'd2) && (quot_wide <= ((64'd1 << DIV_W) - 64'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            meas_reg   <= '0;
            edge_reg   <= '0;
            n_reg      <= '0;
            locked_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            meas_reg   <= meas_next;
            edge_reg   <= edge_next;
            n_reg      <= n_next;
            locked_reg <= locked_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        meas_next    = meas_reg;
        edge_next    = edge_reg;
        n_next       = n_reg;
        locked_next  = locked_reg;
        err_next     = err_reg;
        div_load     = 1'b0;
        div_load_val = bus.manual_div;

        // A start pulse restarts from any state and overrides a simultaneous host write.
        if (bus.autobaud_start) begin
            state_next  = WAIT_FALL;
            meas_next   = '0;
            edge_next   = '0;
            locked_next = 1'b0;
            err_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.manual_div_we && (bus.manual_div >= DIV_W'(2))) begin
                        div_load    = 1'b1;
                        locked_next = 1'b0;
                    end
                end
                WAIT_FALL: begin
                    if (fall) begin
                        meas_next  = '0;
                        edge_next  = 3'd1;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    meas_next = meas_reg + MEAS_W'(1);
                    if (fall) edge_next = edge_reg + 3'd1;
                    if (fall && (edge_reg == 3'(SYNC_EDGES - 1))) begin
                        n_next     = meas_reg + MEAS_W'(1);
                        state_next = CALC;
                    end else if (meas_reg == '1) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
                CALC: begin
                    if (quot_ok) begin
                        div_load     = 1'b1;
                        div_load_val = DIV_W'(quot_wide);
                        locked_next  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .div       (div_load_val),
        .div_load  (div_load),
        .baud_tick (bus.baud_tick),
        .div_out   (bus.div_out)
    );

    assign bus.busy     = (state_reg != IDLE);
    assign bus.locked   = locked_reg;
    assign bus.ab_error = err_reg;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed + randomized bench for uart_autobaud_ctrl with a bit-period level reference model.
// MEAS_W is reduced so counter saturation is reachable in a short run.
module tb_uart_autobaud_ctrl;
    localparam int DIV_W  = 16;
    localparam int MEAS_W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_autobaud_ctrl_if #(.DIV_W(DIV_W)) bus ();

    uart_autobaud_ctrl #(.DIV_W(DIV_W), .MEAS_W(MEAS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_div;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts sampling points (this one is 1) until baud_tick is seen; -1 on timeout.
    task automatic wait_tick(input int limit, output int cycles);
        cycles = 1;
        while (bus.baud_tick !== 1'b1 && cycles <= limit) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles > limit) cycles = -1;
    endtask

    task automatic period(output int p);
        int c;
        wait_tick(1000, c);
        @(negedge clk);
        wait_tick(1000, p);
        if (c < 0) p = -1;
    endtask

    // Reference: 8 bit times of b clocks, divided by 128 rounded = round(b/16).
    function automatic int model_div(input int b);
        return (b + 8) / 16;
    endfunction

    function automatic bit model_ok(input int b);
        return (model_div(b) >= 2) && (model_div(b) <= 65535);
    endfunction

    task automatic send_bits(input int b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.rx = (i % 2 == 1);
            step(b);
        end
    endtask

    task automatic start_ab(input string tag);
        bus.autobaud_start = 1'b1;
        step(1);
        bus.autobaud_start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        check({tag, "_err_clr"}, 32'(bus.ab_error), 0);
        check({tag, "_unlock"}, 32'(bus.locked), 0);
    endtask

    task automatic finish_ab(input int b, input string tag);
        int w;
        int p;
        send_bits(b, 10);
        w = 0;
        while (bus.busy === 1'b1 && w < 40) begin
            step(1);
            w++;
        end
        check({tag, "_done"}, 32'(bus.busy), 0);
        if (model_ok(b)) exp_div = model_div(b);
        check({tag, "_div"}, 32'(bus.div_out), exp_div);
        check({tag, "_locked"}, 32'(bus.locked), model_ok(b) ? 1 : 0);
        check({tag, "_err"}, 32'(bus.ab_error), model_ok(b) ? 0 : 1);
        if (model_ok(b)) begin
            period(p);
            check({tag, "_period"}, 32'(p), exp_div);
        end
        $display("autobaud %s: bit=%0d clk div_out=%0d locked=%0d err=%0d", tag, b,
                 bus.div_out, bus.locked, bus.ab_error);
    endtask

    task automatic manual_write(input int d, input string tag);
        int c;
        bus.manual_div    = DIV_W'(d);
        bus.manual_div_we = 1'b1;
        step(1);
        bus.manual_div_we = 1'b0;
        if (d >= 2) begin
            exp_div = d;
            check({tag, "_unlock"}, 32'(bus.locked), 0);
            check({tag, "_div"}, 32'(bus.div_out), exp_div);
            wait_tick(1000, c);
            check({tag, "_first"}, 32'(c), exp_div);
        end else begin
            check({tag, "_div"}, 32'(bus.div_out), exp_div);
            period(c);
            check({tag, "_period"}, 32'(c), exp_div);
        end
        $display("manual %s: wrote %0d div_out=%0d", tag, d, bus.div_out);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int w;
        int b;
        rst                = 1'b1;
        bus.rx             = 1'b1;
        bus.autobaud_start = 1'b0;
        bus.manual_div_we  = 1'b0;
        bus.manual_div     = '0;
        exp_div            = 325;

        // 1: reset values and first tick
        step(3);
        check("rst_div", 32'(bus.div_out), 325);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.ab_error), 0);
        check("rst_tick", 32'(bus.baud_tick), 0);
        rst = 1'b0;
        wait_tick(400, c);
        check("rst_first_tick", 32'(c), 325);
        $display("reset: div_out=%0d first tick after %0d cycles", bus.div_out, c);

        // 2: manual divisor, then an illegal one
        manual_write(4, "man4");
        period(c);
        check("man4_period", 32'(c), 4);
        manual_write(1, "man1");

        // 3: 0x55 at 160 clk/bit; ticks keep the old divisor while waiting
        start_ab("ab160");
        period(c);
        check("ab160_old_period", 32'(c), 4);
        finish_ab(160, "ab160");

        // 4: line stuck low after one fall saturates the measurement counter
        start_ab("sat");
        bus.rx = 1'b0;
        w = 0;
        while (bus.busy === 1'b1 && w < 5000) begin
            step(1);
            w++;
        end
        check("sat_done", 32'(bus.busy), 0);
        check("sat_err", 32'(bus.ab_error), 1);
        check("sat_div", 32'(bus.div_out), exp_div);
        check("sat_locked", 32'(bus.locked), 0);
        $display("saturate: err=%0d div_out=%0d after %0d cycles", bus.ab_error, bus.div_out, w);
        bus.rx = 1'b1;
        step(4);

        // 5: start+write together, partial frame, restart, write while busy
        bus.manual_div     = DIV_W'(9);
        bus.manual_div_we  = 1'b1;
        bus.autobaud_start = 1'b1;
        step(1);
        bus.manual_div_we  = 1'b0;
        bus.autobaud_start = 1'b0;
        check("tie_busy", 32'(bus.busy), 1);
        check("tie_err_clr", 32'(bus.ab_error), 0);
        check("tie_div", 32'(bus.div_out), exp_div);
        send_bits(50, 5);
        bus.rx = 1'b1;
        step(20);
        check("partial_busy", 32'(bus.busy), 1);
        start_ab("restart");
        bus.manual_div    = DIV_W'(7);
        bus.manual_div_we = 1'b1;
        step(1);
        bus.manual_div_we = 1'b0;
        check("busy_write_div", 32'(bus.div_out), exp_div);
        finish_ab(96, "ab96");

        // 6: too fast a line rounds to divisor 1 and is rejected
        start_ab("ab8");
        finish_ab(8, "ab8");

        // randomized autobaud runs and host writes
        for (int k = 0; k < 4; k++) begin
            b = int'($urandom_range(480, 12));
            start_ab($sformatf("rnd%0d", k));
            finish_ab(b, $sformatf("rnd%0d", k));
            manual_write(int'($urandom_range(40, 2)), $sformatf("rman%0d", k));
            manual_write(int'($urandom_range(1, 0)), $sformatf("rbad%0d", k));
        end

        // reset in the middle of a measurement
        start_ab("midrst");
        send_bits(40, 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.rx = 1'b1;
        exp_div = 325;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_div", 32'(bus.div_out), exp_div);
        check("midrst_locked", 32'(bus.locked), 0);
        check("midrst_err", 32'(bus.ab_error), 0);
        $display("mid-measure reset: busy=%0d div_out=%0d", bus.busy, bus.div_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
